alu_iterative: RTL

Parametrised successor to the single-cycle calculator ALU: ADD/SUB in one execute cycle, MUL by shift-and-add and DIV by restoring division, each over DATA_WIDTH iteration cycles sharing one adder. It also returns a remainder and handles signed operands with sign fix-up. It sits between the calculator's operand/operator front end and the display/result path, with valid-ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_iterative_if.sv | 45 ++++
 rtl/alu_muldiv_core.sv | 194 +++++++++++++++++++
 rtl/alu_iterative.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and encodings for the iterative calculator ALU.
package alu_pkg;

    // Operator encoding as seen on i_alu_input_op.
    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_MUL = 2'b10;
    localparam logic [1:0] ALU_OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        OP_ADD = ALU_OP_ADD,
        OP_SUB = ALU_OP_SUB,
        OP_MUL = ALU_OP_MUL,
        OP_DIV = ALU_OP_DIV
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDSUB,
        ST_PREP,
        ST_ITER,
        ST_FIXUP,
        ST_DONE
    } alu_state_t;

    // Step requested from the datapath core by the control FSM.
    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_PREP,
        CMD_ITER
    } core_cmd_t;

    function automatic logic is_addsub(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Operand/operator request and result/remainder response bundle of the ALU.
// master = calculator front end / result consumer, slave = the ALU.
interface alu_iterative_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] i_alu_input_a;
    logic [DATA_WIDTH-1:0] i_alu_input_b;
    logic [1:0]            i_alu_input_op;
    logic                  i_alu_input_signed;
    logic                  i_alu_input_valid;
    logic                  o_alu_input_ready;
    logic [DATA_WIDTH-1:0] o_alu_result;
    logic [DATA_WIDTH-1:0] o_alu_remainder;
    logic                  o_alu_error;
    logic                  o_alu_result_valid;
    logic                  i_alu_result_ready;

    modport master (
        output i_alu_input_a,
        output i_alu_input_b,
        output i_alu_input_op,
        output i_alu_input_signed,
        output i_alu_input_valid,
        input  o_alu_input_ready,
        input  o_alu_result,
        input  o_alu_remainder,
        input  o_alu_error,
        input  o_alu_result_valid,
        output i_alu_result_ready
    );

    modport slave (
        input  i_alu_input_a,
        input  i_alu_input_b,
        input  i_alu_input_op,
        input  i_alu_input_signed,
        input  i_alu_input_valid,
        output o_alu_input_ready,
        output o_alu_result,
        output o_alu_remainder,
        output o_alu_error,
        output o_alu_result_valid,
        input  i_alu_result_ready
    );
endinterface

// File: rtl/alu_muldiv_core.sv
// Datapath of the iterative ALU: operand registers, 2W accumulator,
// W+1 partial remainder, iteration counter and the single shared adder.
// Shift-and-add multiply and restoring divide run on magnitudes; the sign
// fix-up and the ADD/SUB result are presented combinationally on res/rem.
// Optional feature: define ALU_OVERFLOW_EN to drive the ovf output.
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  core_cmd_t             cmd,
    input  logic [DATA_WIDTH-1:0] load_a,
    input  logic [DATA_WIDTH-1:0] load_b,
    input  alu_op_t               load_op,
    input  logic                  load_signed,
    output logic [DATA_WIDTH-1:0] res,
    output logic [DATA_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  cnt_last
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [W-1:0]   a_q, a_d, b_q, b_d;
    alu_op_t        op_q, op_d;
    logic           a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W:0]     prem_q, prem_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   a_mag, b_mag;
    logic           res_neg;
    logic [W+1:0]   add_x, add_y, add_sum;
    logic           add_sub;

    assign a_mag    = a_neg_q ? -a_q : a_q;
    assign b_mag    = b_neg_q ? -b_q : b_q;
    assign res_neg  = a_neg_q ^ b_neg_q;
    assign cnt_last = (cnt_q == CW'(1));

    // Select operands of the one adder shared by ADD/SUB, MUL and DIV steps.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        case (op_q)
            OP_ADD: begin
                add_x = {2'b00, a_q};
                add_y = {2'b00, b_q};
            end
            OP_SUB: begin
                add_x   = {2'b00, a_q};
                add_y   = {2'b00, b_q};
                add_sub = 1'b1;
            end
            OP_MUL: begin
                add_x = {2'b00, acc_q[2*W-1:W]};
                add_y = {2'b00, a_q};
            end
            OP_DIV: begin
                // Trial subtract of the divisor from {rem, next dividend bit}.
                add_x   = {prem_q, acc_q[W-1]};
                add_y   = {2'b00, b_q};
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_sum = add_x + (add_sub ? ~add_y : add_y) + {{(W+1){1'b0}}, add_sub};

    // Next-state of the datapath registers for the step the FSM requests.
    always_comb begin
        // NOTE: every variable gets a hold value first so no path infers a latch.
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        acc_d   = acc_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        case (cmd)
            CMD_LOAD: begin
                a_d     = load_a;
                b_d     = load_b;
                op_d    = load_op;
                a_neg_d = load_signed & load_a[W-1];
                b_neg_d = load_signed & load_b[W-1];
            end
            CMD_PREP: begin
                a_d    = a_mag;
                b_d    = b_mag;
                prem_d = '0;
                cnt_d  = CW'(W);
                // Upper half cleared; the lower half carries the bits that get
                // consumed one per step (multiplier, or dividend -> quotient).
                acc_d  = {{W{1'b0}}, (op_q == OP_MUL) ? b_mag : a_mag};
            end
            CMD_ITER: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = {(acc_q[0] ? add_sum[W:0] : {1'b0, acc_q[2*W-1:W]}),
                             acc_q[W-1:1]};
                end else if (!add_sum[W+1]) begin
                    prem_d          = add_sum[W:0];
                    acc_d[W-1:0]    = {acc_q[W-2:0], 1'b1};
                end else begin
                    prem_d          = add_x[W:0];
                    acc_d[W-1:0]    = {acc_q[W-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears operands, accumulator and counter.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            acc_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            acc_q   <= acc_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result presentation with sign fix-up (truncating division).
    always_comb begin
        res = add_sum[W-1:0];
        rem = '0;
        case (op_q)
            OP_MUL: res = res_neg ? -acc_q[W-1:0] : acc_q[W-1:0];
            OP_DIV: begin
                res = res_neg ? -acc_q[W-1:0] : acc_q[W-1:0];
                rem = a_neg_q ? -prem_q[W-1:0] : prem_q[W-1:0];
            end
            default: ;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    localparam logic [2*W-1:0] MUL_LIM = (2*W)'(1) << (W - 1);

    logic signed_q, signed_d;

    // Signedness is only needed to pick the overflow rule.
    always_comb begin
        signed_d = signed_q;
        if (cmd == CMD_LOAD) signed_d = load_signed;
    end

    // Operating mode register for the overflow rule.
    always_ff @(posedge clk) begin
        if (rst) signed_q <= 1'b0;
        else     signed_q <= signed_d;
    end

    // Overflow of the wrapped result, evaluated on raw operands for ADD/SUB
    // and on the finished magnitudes for MUL/DIV.
    always_comb begin
        ovf = 1'b0;
        case (op_q)
            OP_ADD: ovf = signed_q ? ((a_q[W-1] == b_q[W-1]) && (add_sum[W-1] != a_q[W-1]))
                                   : add_sum[W];
            OP_SUB: ovf = signed_q ? ((a_q[W-1] != b_q[W-1]) && (add_sum[W-1] != a_q[W-1]))
                                   : (a_q < b_q);
            OP_MUL: ovf = signed_q ? (res_neg ? (acc_q > MUL_LIM) : (acc_q >= MUL_LIM))
                                   : (|acc_q[2*W-1:W]);
            OP_DIV: ovf = signed_q && !res_neg && acc_q[W-1];
            default: ;
        endcase
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_iterative.sv
// Iterative ALU top: control FSM, valid/ready handshakes and the registered
// result/remainder/error/valid outputs. Arithmetic lives in alu_muldiv_core.
// Optional feature: ALU_OVERFLOW_EN adds overflow to o_alu_error.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_iterative_if.slave bus
);

    alu_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic                  error_q, error_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;

    core_cmd_t             core_cmd;
    logic [DATA_WIDTH-1:0] core_res, core_rem;
    logic                  core_ovf, core_cnt_last;
    alu_op_t               in_op;

    assign in_op = alu_op_t'(bus.i_alu_input_op);

    alu_muldiv_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .cmd        (core_cmd),
        .load_a     (bus.i_alu_input_a),
        .load_b     (bus.i_alu_input_b),
        .load_op    (in_op),
        .load_signed(bus.i_alu_input_signed),
        .res        (core_res),
        .rem        (core_rem),
        .ovf        (core_ovf),
        .cnt_last   (core_cnt_last)
    );

    // Next state, core step and next output values for the current state.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        error_d     = error_q;
        valid_d     = valid_q;
        ready_d     = ready_q;
        core_cmd    = CMD_NONE;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_alu_input_valid && ready_q) begin
                    core_cmd = CMD_LOAD;
                    ready_d  = 1'b0;
                    if (is_addsub(in_op)) begin
                        state_d = ST_ADDSUB;
                    end else if ((in_op == OP_DIV) && (bus.i_alu_input_b == '0)) begin
                        state_d     = ST_DONE;
                        result_d    = '1;
                        remainder_d = bus.i_alu_input_a;
                        error_d     = 1'b1;
                        valid_d     = 1'b1;
                    end else begin
                        state_d = ST_PREP;
                    end
                end
            end
            ST_ADDSUB: begin
                result_d    = core_res;
                remainder_d = '0;
                error_d     = core_ovf;
                valid_d     = 1'b1;
                state_d     = ST_DONE;
            end
            ST_PREP: begin
                core_cmd = CMD_PREP;
                state_d  = ST_ITER;
            end
            ST_ITER: begin
                core_cmd = CMD_ITER;
                if (core_cnt_last) state_d = ST_FIXUP;
            end
            ST_FIXUP: begin
                result_d    = core_res;
                remainder_d = core_rem;
                error_d     = core_ovf;
                valid_d     = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                // Leaving DONE re-opens the input only from the next cycle on.
                if (bus.i_alu_result_ready) begin
                    valid_d = 1'b0;
                    error_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered handshake/result outputs; reset aborts any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            remainder_q <= '0;
            error_q     <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            error_q     <= error_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.o_alu_input_ready  = ready_q;
    assign bus.o_alu_result       = result_q;
    assign bus.o_alu_remainder    = remainder_q;
    assign bus.o_alu_error        = error_q;
    assign bus.o_alu_result_valid = valid_q;

endmodule
